fmeter: RTL and testbench

- Equal-precision (reciprocal) frequency meter for the DSO trigger/measurement path.
- The gate is requested by software (`ss`) but opens and closes only on rising edges of the unknown signal `fx`. The gate is therefore an exact whole number of `fx` periods.
- During the gate, the block counts `fx` periods (`cntx`) and reference-clock cycles (`cnts`).
- Firmware computes f_x = f_s × cntx / cnts.

---
 rtl/fmeter_pkg.sv | 13 +
 rtl/fmeter_sync_edge_det.sv | 32 +++
 rtl/fmeter.sv | 102 ++++++++++
 tb/tb_fmeter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fmeter_pkg.sv
// Shared defaults and gate state encoding for the reciprocal frequency meter.
package fmeter_pkg;

    localparam int unsigned FM_WIDTH_DEF = 20;
    localparam int unsigned FM_SYNC_DEF  = 2;
    localparam int unsigned FM_SYNC_MIN  = 2;

    typedef enum logic {
        GATE_CLOSED = 1'b0,
        GATE_OPEN   = 1'b1
    } gate_e;

endpackage

// File: rtl/fmeter_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input followed by a one-cycle
// rising-edge pulse; synchronous active-high clear zeroes every flop.
module fmeter_sync_edge_det
    import fmeter_pkg::*;
#(
    parameter int unsigned STAGES = FM_SYNC_DEF
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_d,
    output logic o_rise_c
);

    // Fewer than two stages is not a safe synchroniser, so clamp upward.
    localparam int unsigned N = (STAGES < FM_SYNC_MIN) ? FM_SYNC_MIN : STAGES;

    logic [N-1:0] r_sync;
    logic         r_hist;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
            r_hist <= r_sync[N-1];
        end
    end

    assign o_rise_c = r_sync[N-1] & ~r_hist;

endmodule

// File: rtl/fmeter.sv
// Equal-precision frequency meter: gate opens/closes on synchronised fx rising
// edges, counting whole fx periods (cntx) and reference cycles (cnts) inside it.
module fmeter
    import fmeter_pkg::*;
#(
    parameter int unsigned WIDTH       = FM_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = FM_SYNC_DEF
) (
    input  logic             fs,
    input  logic             clr,
    input  logic             fx,
    input  logic             ss,
    output logic             sta,
    output logic             ovx,
    output logic             ovs,
    output logic [WIDTH-1:0] cntx,
    output logic [WIDTH-1:0] cnts
);

    gate_e            r_state;
    gate_e            w_state_nxt;
    logic             w_rise;
    logic             w_cnts_en;
    logic             w_cntx_en;
    logic [WIDTH-1:0] r_cntx;
    logic [WIDTH-1:0] r_cnts;
    logic             r_ovx;
    logic             r_ovs;

    fmeter_sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk    (fs),
        .i_clr    (clr),
        .i_d      (fx),
        .o_rise_c (w_rise)
    );

    always_ff @(posedge fs) begin
        if (clr) begin
            r_state <= GATE_CLOSED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Gate only changes on an fx rising edge, taking the current ss request.
    always_comb begin
        w_state_nxt = r_state;
        w_cnts_en   = 1'b0;
        w_cntx_en   = 1'b0;
        case (r_state)
            GATE_CLOSED: begin
                if (w_rise && ss) begin
                    w_state_nxt = GATE_OPEN;
                end
            end
            GATE_OPEN: begin
                w_cnts_en = 1'b1;
                w_cntx_en = w_rise;
                if (w_rise && !ss) begin
                    w_state_nxt = GATE_CLOSED;
                end
            end
            default: begin
                w_state_nxt = GATE_CLOSED;
            end
        endcase
    end

    // Saturating counters with sticky overflow flags.
    always_ff @(posedge fs) begin
        if (clr) begin
            r_cntx <= '0;
            r_cnts <= '0;
            r_ovx  <= 1'b0;
            r_ovs  <= 1'b0;
        end else begin
            if (w_cnts_en) begin
                if (&r_cnts) begin
                    r_ovs <= 1'b1;
                end else begin
                    r_cnts <= r_cnts + WIDTH'(1);
                end
            end
            if (w_cntx_en) begin
                if (&r_cntx) begin
                    r_ovx <= 1'b1;
                end else begin
                    r_cntx <= r_cntx + WIDTH'(1);
                end
            end
        end
    end

    assign sta  = (r_state == GATE_OPEN);
    assign ovx  = r_ovx;
    assign ovs  = r_ovs;
    assign cntx = r_cntx;
    assign cnts = r_cnts;

endmodule

// File: tb/tb_fmeter.sv
// Directed bench for fmeter: 20-bit instance for ratio/gate behaviour and an
// 8-bit instance for saturation, sharing one stimulus.
module tb_fmeter;

    logic        fs;
    logic        clr;
    logic        fx;
    logic        ss;
    logic        sta, ovx, ovs;
    logic [19:0] cntx, cnts;
    logic        sta8, ovx8, ovs8;
    logic [7:0]  cntx8, cnts8;

    int          fx_mode;
    int          phase;
    logic        fx_sync;
    logic        fx_async;
    int          n_checks;
    int          n_fail;

    fmeter #(.WIDTH(20), .SYNC_STAGES(2)) u_dut (
        .fs(fs), .clr(clr), .fx(fx), .ss(ss),
        .sta(sta), .ovx(ovx), .ovs(ovs), .cntx(cntx), .cnts(cnts)
    );

    fmeter #(.WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
        .fs(fs), .clr(clr), .fx(fx), .ss(ss),
        .sta(sta8), .ovx(ovx8), .ovs(ovs8), .cntx(cntx8), .cnts(cnts8)
    );

    initial begin
        fs = 1'b0;
        forever #5 fs = ~fs;
    end

    // fx locked to fs: period 20 cycles, high while phase 0..9, updated just after posedge.
    initial begin
        phase   = 19;
        fx_sync = 1'b0;
        forever begin
            @(posedge fs);
            #2;
            phase   = (phase == 19) ? 0 : phase + 1;
            fx_sync = (phase < 10);
        end
    end

    initial begin
        fx_async = 1'b0;
        forever #99 fx_async = ~fx_async;
    end

    assign fx = (fx_mode == 2) ? fx_async : ((fx_mode == 1) ? fx_sync : 1'b0);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 40 && phase != p; i++) @(negedge fs);
    endtask

    // Clear while fx_sync is low so the flushed synchroniser cannot fake a rise.
    task automatic clr_low();
        wait_phase(11);
        clr = 1'b1;
        repeat (2) @(negedge fs);
        clr = 1'b0;
        @(negedge fs);
    endtask

    task automatic wait_closed(input int budget);
        for (int i = 0; i < budget && sta !== 1'b0; i++) @(negedge fs);
    endtask

    int lat;
    int seen;
    int diff;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        fx_mode  = 0;
        clr      = 1'b0;
        ss       = 1'b0;

        // Reset
        @(negedge fs);
        clr = 1'b1;
        repeat (2) @(negedge fs);
        clr = 1'b0;
        check_eq("rst_sta",  32'(sta),  0);
        check_eq("rst_ovx",  32'(ovx),  0);
        check_eq("rst_ovs",  32'(ovs),  0);
        check_eq("rst_cntx", 32'(cntx), 0);
        check_eq("rst_cnts", 32'(cnts), 0);

        // Exact ratio: gate spans 5 periods of 20 cycles
        fx_mode = 1;
        repeat (25) @(negedge fs);
        clr_low();
        ss = 1'b1;
        repeat (100) @(negedge fs);
        ss = 1'b0;
        wait_closed(40);
        check_eq("exact_closed", 32'(sta),  0);
        check_eq("exact_cntx",   32'(cntx), 5);
        check_eq("exact_cnts",   32'(cnts), 100);
        check_eq("exact_ovs",    32'(ovs),  0);

        // Short ss pulse between two rise pulses
        clr_low();
        wait_phase(7);
        ss = 1'b1;
        wait_phase(10);
        ss = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge fs);
            if (sta === 1'b1) seen = 1;
        end
        check_eq("short_sta",  32'(seen), 0);
        check_eq("short_cntx", 32'(cntx), 0);
        check_eq("short_cnts", 32'(cnts), 0);

        // clr mid-gate, then reopen and count from zero
        clr_low();
        ss = 1'b1;
        for (int i = 0; i < 40 && sta !== 1'b1; i++) @(negedge fs);
        check_eq("mid_opened", 32'(sta), 1);
        repeat (5) @(negedge fs);
        wait_phase(11);
        clr = 1'b1;
        @(negedge fs);
        clr = 1'b0;
        check_eq("mid_clr_sta",  32'(sta),  0);
        check_eq("mid_clr_cntx", 32'(cntx), 0);
        check_eq("mid_clr_cnts", 32'(cnts), 0);
        check_eq("mid_clr_ovx",  32'(ovx),  0);
        check_eq("mid_clr_ovs",  32'(ovs),  0);
        for (int i = 0; i < 40 && sta !== 1'b1; i++) @(negedge fs);
        check_eq("mid_reopen",      32'(sta),  1);
        check_eq("mid_reopen_cnts", 32'(cnts), 0);
        check_eq("mid_reopen_cntx", 32'(cntx), 0);
        repeat (20) @(negedge fs);
        check_eq("mid_period_cnts", 32'(cnts), 20);
        check_eq("mid_period_cntx", 32'(cntx), 1);
        ss = 1'b0;
        wait_closed(40);
        check_eq("mid_closed", 32'(sta), 0);

        // Overflow on the 8-bit instance
        clr_low();
        ss = 1'b1;
        repeat (400) @(negedge fs);
        ss = 1'b0;
        for (int i = 0; i < 40 && sta8 !== 1'b0; i++) @(negedge fs);
        check_eq("ovf_closed", 32'(sta8),  0);
        check_eq("ovf_cnts",   32'(cnts8), 255);
        check_eq("ovf_ovs",    32'(ovs8),  1);
        check_eq("ovf_ovx",    32'(ovx8),  0);
        check_eq("ovf_cntx",   32'(cntx8), 20);
        repeat (30) @(negedge fs);
        check_eq("ovf_ovs_sticky", 32'(ovs8),  1);
        check_eq("ovf_cnts_hold",  32'(cnts8), 255);
        clr_low();
        check_eq("ovf_clr_ovs",  32'(ovs8),  0);
        check_eq("ovf_clr_ovx",  32'(ovx8),  0);
        check_eq("ovf_clr_cnts", 32'(cnts8), 0);
        check_eq("ovf_clr_cntx", 32'(cntx8), 0);
        check_eq("ovf_clr_sta",  32'(sta8),  0);

        // Asynchronous fx, period 198 ns
        fx_mode = 2;
        repeat (10) @(negedge fs);
        clr = 1'b1;
        repeat (2) @(negedge fs);
        clr = 1'b0;
        repeat (5) @(negedge fs);
        ss  = 1'b1;
        lat = 999;
        for (int i = 1; i <= 100; i++) begin
            @(negedge fs);
            if (sta === 1'b1 && lat == 999) lat = i;
        end
        ss = 1'b0;
        check_eq("async_open_lat", 32'(lat <= 23), 1);
        wait_closed(40);
        check_eq("async_closed", 32'(sta), 0);
        check_eq("async_cntx_range", 32'(cntx == 5 || cntx == 6), 1);
        diff = 10 * int'(cnts) - 198 * int'(cntx);
        check_eq("async_ratio", 32'(diff >= -10 && diff <= 10), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
